// File: rtl/bus_master_if_if.sv
// Handshake bundle between a pipeline memory stage, its bus master port and the arbitrated bus.
// The master modport is the bus_master_if view; slave is the pipeline/arbiter/slave side.
interface bus_master_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              busy;
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wr_data, bus_grnt_, bus_rd_data, bus_rdy_,
    output cpu_rd_data, busy, bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data
  );

  modport slave (
    output cpu_req, cpu_rw, cpu_addr, cpu_wr_data, bus_grnt_, bus_rd_data, bus_rdy_,
    input  cpu_rd_data, busy, bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data
  );
endinterface

// File: rtl/bus_master_if.sv
// Requesting end of the arbitrated bus: takes one single-word access from a pipeline stage,
// wins the bus, runs one strobed address/data transfer and hands read data back.
//
// state  | meaning
// IDLE   | no access in flight; a cpu_req latches the request
// REQ    | bus_req_ asserted, waiting for grant
// ACCESS | owning the bus, address/data driven, waiting for bus_rdy_
// DONE   | bus released, result valid, pipeline allowed to advance
module bus_master_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            reset_,
  bus_master_if_if.master bif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] data_q;

  assign bif.busy = ((state == IDLE) && bif.cpu_req) || (state == REQ) || (state == ACCESS);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state           <= IDLE;
      addr_q          <= '0;
      rw_q            <= 1'b0;
      data_q          <= '0;
      bif.cpu_rd_data <= '0;
      bif.bus_req_    <= 1'b1;
      bif.bus_as_     <= 1'b1;
      bif.bus_rw      <= 1'b1;
      bif.bus_addr    <= '0;
      bif.bus_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bif.cpu_req) begin
            addr_q       <= bif.cpu_addr;
            rw_q         <= bif.cpu_rw;
            data_q       <= bif.cpu_wr_data;
            bif.bus_req_ <= 1'b0;
            state        <= REQ;
          end
        end
        REQ: begin
          // Grant is only honoured here, so a default-owner grant while idle is harmless.
          if (!bif.bus_grnt_) begin
            bif.bus_as_     <= 1'b0;
            bif.bus_addr    <= addr_q;
            bif.bus_rw      <= rw_q;
            bif.bus_wr_data <= data_q;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          bif.bus_as_ <= 1'b1;
          if (!bif.bus_rdy_) begin
            if (rw_q) begin
              bif.cpu_rd_data <= bif.bus_rd_data;
            end
            bif.bus_req_    <= 1'b1;
            bif.bus_addr    <= '0;
            bif.bus_rw      <= 1'b1;
            bif.bus_wr_data <= '0;
            state           <= DONE;
          end
        end
        DONE: begin
          // cpu_req still holds the finished request here; only IDLE may start a new one.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: a transaction-level model checked every cycle plus
// hand-computed literal expectations per scenario.
module tb_bus_master_if;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic clk;
  logic reset_;
  bus_master_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bif    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access is either waiting for the bus, on the bus, or just finished.
  bit              m_waiting, m_on_bus, m_first, m_finished;
  logic [ADDR_W-1:0] m_addr;
  logic              m_rw;
  logic [DATA_W-1:0] m_wd;
  logic [DATA_W-1:0] m_rd;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m_waiting = 0; m_on_bus = 0; m_first = 0; m_finished = 0;
      m_addr = '0; m_rw = 1'b0; m_wd = '0; m_rd = '0;
    end else if (m_finished) begin
      m_finished = 0;
    end else if (m_on_bus) begin
      m_first = 0;
      if (!bif.bus_rdy_) begin
        if (m_rw) m_rd = bif.bus_rd_data;
        m_on_bus   = 0;
        m_finished = 1;
      end
    end else if (m_waiting) begin
      if (!bif.bus_grnt_) begin
        m_waiting = 0;
        m_on_bus  = 1;
        m_first   = 1;
      end
    end else if (bif.cpu_req) begin
      m_addr    = bif.cpu_addr;
      m_rw      = bif.cpu_rw;
      m_wd      = bif.cpu_wr_data;
      m_waiting = 1;
    end
  end

  always @(negedge clk) begin
    if (reset_ && run) begin
      chk("busy",        bif.busy,        (m_waiting || m_on_bus || (!m_finished && bif.cpu_req)));
      chk("bus_req_",    bif.bus_req_,    !(m_waiting || m_on_bus));
      chk("bus_as_",     bif.bus_as_,     !(m_on_bus && m_first));
      chk("bus_addr",    bif.bus_addr,    m_on_bus ? m_addr : '0);
      chk("bus_rw",      bif.bus_rw,      m_on_bus ? m_rw : 1'b1);
      chk("bus_wr_data", bif.bus_wr_data, m_on_bus ? m_wd : '0);
      chk("cpu_rd_data", bif.cpu_rd_data, m_rd);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    bif.cpu_req     = 1'b0;
    bif.cpu_rw      = 1'b1;
    bif.cpu_addr    = '0;
    bif.cpu_wr_data = '0;
    bif.bus_grnt_   = 1'b1;
    bif.bus_rdy_    = 1'b1;
    bif.bus_rd_data = '0;
  endtask

  // One access: grant arrives gd cycles late, slave adds ws wait states. cpu_addr switches to
  // a2 and cpu_wr_data is inverted after the request cycle to prove the latched copy is used.
  task automatic run_txn(input bit rw, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] a2,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                         input int gd, input int ws, input bit early, input bit idle_after,
                         output int busy_n, output int as_n, output logic [ADDR_W-1:0] strobe_addr,
                         output int wd_n, output logic [DATA_W-1:0] done_rd);
    int last;
    last = 3 + gd + ws;
    busy_n = 0; as_n = 0; wd_n = 0; strobe_addr = '0; done_rd = '0;
    for (int k = 0; k <= last; k++) begin
      bif.cpu_req     = 1'b1;
      bif.cpu_rw      = rw;
      bif.cpu_addr    = (k == 0) ? a : a2;
      bif.cpu_wr_data = (k == 0) ? wd : ~wd;
      bif.bus_grnt_   = !(k == 1 + gd);
      bif.bus_rdy_    = !((k == 2 + gd + ws) || (early && k < 2 + gd + ws));
      bif.bus_rd_data = rd;
      @(negedge clk);
      if (bif.busy) busy_n++;
      if (!bif.bus_as_) begin
        as_n++;
        strobe_addr = bif.bus_addr;
      end
      if (bif.bus_wr_data == wd) wd_n++;
      if (k == last) done_rd = bif.cpu_rd_data;
      nxt();
    end
    if (idle_after) begin
      set_idle();
      nxt();
    end
  endtask

  initial begin
    int busy_n, as_n, wd_n;
    logic [ADDR_W-1:0] sa;
    logic [DATA_W-1:0] drd;

    set_idle();
    reset_ = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_ = 1'b1;
    @(negedge clk);
    chk("rst_busy",     bif.busy,        1'b0);
    chk("rst_bus_req_", bif.bus_req_,    1'b1);
    chk("rst_bus_as_",  bif.bus_as_,     1'b1);
    chk("rst_bus_rw",   bif.bus_rw,      1'b1);
    chk("rst_bus_addr", bif.bus_addr,    '0);
    chk("rst_rd_data",  bif.cpu_rd_data, '0);
    nxt();
    run = 1'b1;

    // 1: zero-wait read, rdy_ already low during REQ
    run_txn(1'b1, 30'h100, 30'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b1, 1'b1,
            busy_n, as_n, sa, wd_n, drd);
    chk("t1_busy_cycles", busy_n, 3);
    chk("t1_as_cycles",   as_n,   1);
    chk("t1_strobe_addr", sa,     30'h100);
    chk("t1_rd_data",     drd,    32'hDEAD_BEEF);

    // 2: write with two wait states
    run_txn(1'b0, 30'h3FF, 30'h3FF, 32'h1234_5678, 32'hCAFE_0000, 0, 2, 1'b0, 1'b1,
            busy_n, as_n, sa, wd_n, drd);
    chk("t2_busy_cycles", busy_n, 5);
    chk("t2_as_cycles",   as_n,   1);
    chk("t2_wr_data_cyc", wd_n,   3);
    chk("t2_rd_unchanged", drd,   32'hDEAD_BEEF);

    // 3: grant withheld for 4 cycles
    run_txn(1'b1, 30'h2A, 30'h2A, 32'h0, 32'h0BAD_F00D, 4, 0, 1'b0, 1'b1,
            busy_n, as_n, sa, wd_n, drd);
    chk("t3_busy_cycles", busy_n, 7);
    chk("t3_as_cycles",   as_n,   1);
    chk("t3_rd_data",     drd,    32'h0BAD_F00D);

    // 4: default-owner grant while idle
    set_idle();
    bif.bus_grnt_ = 1'b0;
    for (int i = 0; i < 10; i++) nxt();
    @(negedge clk);
    chk("t4_bus_req_", bif.bus_req_, 1'b1);
    chk("t4_busy",     bif.busy,     1'b0);
    chk("t4_bus_addr", bif.bus_addr, '0);
    nxt();
    set_idle();
    nxt();

    // 5: address changes during REQ; cpu_req held through DONE into a second access
    run_txn(1'b1, 30'h10, 30'h20, 32'h0, 32'h1111_2222, 1, 0, 1'b0, 1'b0,
            busy_n, as_n, sa, wd_n, drd);
    chk("t5_strobe_addr", sa,     30'h10);
    chk("t5_busy_cycles", busy_n, 4);
    run_txn(1'b1, 30'h20, 30'h20, 32'h0, 32'h3333_4444, 0, 0, 1'b0, 1'b1,
            busy_n, as_n, sa, wd_n, drd);
    chk("t5b_busy_cycles", busy_n, 3);
    chk("t5b_strobe_addr", sa,     30'h20);
    chk("t5b_rd_data",     drd,    32'h3333_4444);

    // 6: reset in the middle of ACCESS with the slave stalling
    bif.cpu_req = 1'b1; bif.cpu_rw = 1'b1; bif.cpu_addr = 30'h55;
    nxt();
    bif.bus_grnt_ = 1'b0;
    nxt();
    bif.bus_grnt_ = 1'b1;
    nxt();
    @(negedge clk);
    chk("t6_in_access_as_", bif.bus_as_, 1'b1);
    chk("t6_in_access_req_", bif.bus_req_, 1'b0);
    #1;
    run = 1'b0;
    bif.cpu_req = 1'b0;
    reset_ = 1'b0;
    #1;
    chk("t6_async_bus_req_", bif.bus_req_, 1'b1);
    chk("t6_async_bus_as_",  bif.bus_as_,  1'b1);
    chk("t6_async_bus_addr", bif.bus_addr, '0);
    chk("t6_async_rd_data",  bif.cpu_rd_data, '0);
    nxt();
    reset_ = 1'b1;
    set_idle();
    nxt();
    run = 1'b1;
    @(negedge clk);
    chk("t6_busy_after", bif.busy, 1'b0);
    nxt();
    nxt();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
